acc_op_sequencer: RTL
=====================

Name: acc_op_sequencer

Overview:
Command sequencer directly upstream of the 4-bit accumulator register stage. Accepts accumulate commands over a valid/ready handshake and expands each one into a run of per-cycle control strobes for the accumulator:
- s1: add operand r2
- s2: increment

Supports repeated add, subtract (two's-complement operand), increment and timed wait. Issues a done pulse on the last strobe of each command.

Parameters:
WIDTH, 4, operand width; equals accumulator register width
CNT_W, 4, repeat-count width; a command runs rep+1 cycles (1..2^CNT_W)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command this cycle
cmd_op  input  2  00 WAIT, 01 ADD, 10 INC, 11 SUB
cmd_arg  input  WIDTH  operand for ADD/SUB; ignored for WAIT/INC
cmd_rep  input  CNT_W  repeat count; command occupies cmd_rep+1 issue cycles
flush  input  1  synchronous abort of the current command
s1  output  1  accumulator add strobe (registered)
s2  output  1  accumulator increment strobe (registered)
r2  output  WIDTH  accumulator operand (registered)
busy  output  1  command in progress (state ISSUE)
done  output  1  one-cycle pulse coinciding with the last issue cycle

Behaviour:
- Reset: clk is the single clock. rst is asynchronous and active-high.
  - While rst=1: state IDLE, s1=0, s2=0, r2=0, done=0, busy=0, cnt=0, cmd_ready=0.
  - rst mid-command aborts immediately; no done, no further strobes.
- States: IDLE, ISSUE.
- Accept: on a rising edge with cmd_valid & cmd_ready.
- cmd_ready (combinational from registered state): 1 when rst=0 and (state=IDLE, or state=ISSUE with cnt=0 and flush=0). Inputs are ignored when cmd_ready=0.
- On accept:
  - Next state is ISSUE; cnt <= cmd_rep.
  - Registered outputs load at the same edge, so strobes appear in the cycle after the accept edge. Latency from accept to first strobe is 1 edge.
- Output encoding per op, constant for the whole command:
  - WAIT: s1=0, s2=0, r2=0
  - ADD: s1=1, s2=0, r2=cmd_arg
  - INC: s1=0, s2=1, r2=0
  - SUB: s1=1, s2=0, r2=(~cmd_arg+1) mod 2^WIDTH; arg 0 gives r2=0
- Invariant: s1 and s2 are never both 1. r2=0 whenever s1=0.
- ISSUE, cnt>0: cnt decrements each edge; outputs hold.
- ISSUE, cnt=0 (last cycle): done=1.
  - At the next edge with an accept: load the new command (back-to-back, no bubble).
  - At the next edge without an accept: go to IDLE; s1=s2=r2=0.
- Throughput: a command of rep R occupies exactly R+1 consecutive strobe cycles. Back-to-back streams have zero gaps.
- flush=1 at an edge in ISSUE:
  - Next state IDLE; s1=s2=r2=0; no done pulse.
  - cmd_ready=0 during that cycle, so no accept coincides with a flush.
- flush in IDLE: no effect.
- busy = (state=ISSUE).
- done depends only on state and cnt, so it is asserted even for WAIT.
- Width rules:
  - Operand arithmetic is modulo 2^WIDTH.
  - The repeat counter never wraps; cmd_rep=2^CNT_W-1 yields 2^CNT_W cycles.
  - Downstream accumulator overflow is not this block's concern.

Test Plan:
- Reset: hold rst=1 for 3 cycles with cmd_valid=1 -> s1=s2=r2=0 and cmd_ready=0 throughout. Release rst -> cmd_ready=1, busy=0.
- ADD arg=3 rep=2 into an accumulator at 0 -> s1=1, r2=3 for exactly 3 cycles starting 1 edge after accept; done only on the 3rd; accumulator reads 9; s2 stays 0.
- SUB arg=1 rep=0 after the above -> one cycle of s1=1, r2=15; accumulator 9->8. SUB arg=0 -> r2=0.
- INC rep=15 -> s2=1 for 16 cycles, 4-bit accumulator wraps back to its start value, one done pulse. Then WAIT rep=1 -> 2 cycles with s1=s2=0, busy=1, done on the 2nd.
- Back-to-back: ADD arg=2 rep=0, then INC rep=1, presented with cmd_valid held high -> strobes s1 (r2=2), s2, s2 in consecutive cycles; cmd_ready=1 in IDLE and at each cnt=0; accumulator +4.
- Abort: ADD arg=5 rep=7, flush at the 3rd strobe -> strobes stop next edge, no done, accumulator +15. Repeat with rst pulsed mid-command -> outputs 0 asynchronously, IDLE after release.

Source files
------------

// File: rtl/acc_op_sequencer.sv
// ---------------------------------------------------------------------------
// acc_op_sequencer
//
// Command sequencer sitting directly in front of the accumulator register
// stage. Accepts one command per valid/ready handshake and expands it into a
// run of rep+1 consecutive per-cycle strobes for the accumulator:
//   s1 : add operand r2 to the accumulator
//   s2 : increment the accumulator
// Supported operations: WAIT (no strobe), ADD (s1 with the operand), INC (s2)
// and SUB (s1 with the two's-complement negated operand). done pulses on the
// last strobe cycle of every command, including WAIT.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   cmd_valid  in   command present
//   cmd_ready  out  command can be accepted this cycle
//   cmd_op     in   00 WAIT, 01 ADD, 10 INC, 11 SUB
//   cmd_arg    in   operand for ADD/SUB (ignored for WAIT/INC)
//   cmd_rep    in   repeat count, command occupies cmd_rep+1 strobe cycles
//   flush      in   synchronous abort of the command in progress
//   s1         out  registered add strobe
//   s2         out  registered increment strobe
//   r2         out  registered operand (zero whenever s1 is low)
//   busy       out  a command is being issued
//   done       out  last strobe cycle of the current command
// ---------------------------------------------------------------------------
module acc_op_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic [CNT_W-1:0] cmd_rep,
  input  logic             flush,
  output logic             s1,
  output logic             s2,
  output logic [WIDTH-1:0] r2,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam logic [1:0] OP_WAIT = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_INC  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  // Two's-complement negation modulo 2^WIDTH; an operand of 0 stays 0.
  function automatic logic signed [WIDTH-1:0] neg_wrap(
    input logic signed [WIDTH-1:0] a
  );
    logic signed [WIDTH-1:0] one;
    one = WIDTH'(1);
    return (~a) + one;
  endfunction

  // Decoded strobe set for a newly accepted command.
  state_t                  state_p1, state_p0;
  logic [CNT_W-1:0]        cnt_p1, cnt_p0;
  logic                    s1_p1, s1_p0;
  logic                    s2_p1, s2_p0;
  logic signed [WIDTH-1:0] r2_p1, r2_p0;

  logic                    ld_s1, ld_s2;
  logic signed [WIDTH-1:0] ld_r2;
  logic                    last_cyc;
  logic                    ready_core;
  logic                    accept;

  assign last_cyc = (state_p1 == ISSUE) && (cnt_p1 == '0);

  // ready_core deliberately excludes rst: while rst is high every register is
  // held in reset, so the handshake only has to be masked at the port.
  assign ready_core = (state_p1 == IDLE) || (last_cyc && !flush);
  assign accept     = cmd_valid && ready_core;

  always_comb begin
    ld_s1 = 1'b0;
    ld_s2 = 1'b0;
    ld_r2 = '0;
    case (cmd_op)
      OP_ADD: begin
        ld_s1 = 1'b1;
        ld_r2 = $signed(cmd_arg);
      end
      OP_INC: begin
        ld_s2 = 1'b1;
      end
      OP_SUB: begin
        ld_s1 = 1'b1;
        ld_r2 = neg_wrap($signed(cmd_arg));
      end
      OP_WAIT: begin
        ld_s1 = 1'b0;
      end
      default: begin
        ld_s1 = 1'b0;
      end
    endcase
  end

  // Next-state / next-strobe selection. Strobes are constant for the whole
  // command, so they only change on a load or when leaving ISSUE.
  always_comb begin
    state_p0 = state_p1;
    cnt_p0   = cnt_p1;
    s1_p0    = s1_p1;
    s2_p0    = s2_p1;
    r2_p0    = r2_p1;
    case (state_p1)
      IDLE: begin
        if (accept) begin
          state_p0 = ISSUE;
          cnt_p0   = cmd_rep;
          s1_p0    = ld_s1;
          s2_p0    = ld_s2;
          r2_p0    = ld_r2;
        end
      end
      ISSUE: begin
        if (flush) begin
          state_p0 = IDLE;
          cnt_p0   = '0;
          s1_p0    = 1'b0;
          s2_p0    = 1'b0;
          r2_p0    = '0;
        end else if (cnt_p1 != '0) begin
          cnt_p0 = cnt_p1 - CNT_W'(1);
        end else if (accept) begin
          // Back-to-back: next command starts with no bubble.
          state_p0 = ISSUE;
          cnt_p0   = cmd_rep;
          s1_p0    = ld_s1;
          s2_p0    = ld_s2;
          r2_p0    = ld_r2;
        end else begin
          state_p0 = IDLE;
          s1_p0    = 1'b0;
          s2_p0    = 1'b0;
          r2_p0    = '0;
        end
      end
      default: begin
        state_p0 = IDLE;
        cnt_p0   = '0;
        s1_p0    = 1'b0;
        s2_p0    = 1'b0;
        r2_p0    = '0;
      end
    endcase
  end

  // ---- stage p1: state, repeat counter and registered strobes ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1 <= IDLE;
      cnt_p1   <= '0;
      s1_p1    <= 1'b0;
      s2_p1    <= 1'b0;
      r2_p1    <= '0;
    end else begin
      state_p1 <= state_p0;
      cnt_p1   <= cnt_p0;
      s1_p1    <= s1_p0;
      s2_p1    <= s2_p0;
      r2_p1    <= r2_p0;
    end
  end

  assign cmd_ready = ready_core && !rst;
  assign busy      = (state_p1 == ISSUE);
  assign done      = last_cyc;
  assign s1        = s1_p1;
  assign s2        = s2_p1;
  assign r2        = r2_p1;

endmodule
